// File: rtl/lc4_decode_queue.sv
// Buffered decode stage for the 20-bit LC4-ECC ISA: instruction FIFO, head decoder,
// pending-write scoreboard and a single valid/ready output register toward execute.
module lc4_decode_queue #(
    parameter int unsigned INSN_W = 20,
    parameter int unsigned OP_W   = 5,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [INSN_W-1:0]        i_in_insn,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic                     i_flush,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [INSN_W-1:0]        o_out_insn,
    output logic [REG_W-1:0]         o_out_r1sel,
    output logic [REG_W-1:0]         o_out_r2sel,
    output logic [REG_W-1:0]         o_out_wsel,
    output logic                     o_out_r1re,
    output logic                     o_out_r2re,
    output logic                     o_out_regfile_we,
    output logic                     o_out_nzp_we,
    output logic                     o_out_select_pc_plus_one,
    output logic                     o_out_is_branch,
    output logic                     o_out_is_control_insn,
    input  logic                     i_wb_valid,
    input  logic [REG_W-1:0]         i_wb_sel,
    output logic                     o_stall_hazard,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned NREG  = 2 ** REG_W;
    localparam logic [REG_W-1:0] LINK_REG = REG_W'(7);

    logic [INSN_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [NREG-1:0]   r_pending;

    logic [INSN_W-1:0] w_head;
    logic [OP_W-1:0]   w_op;
    logic [31:0]       w_op_idx;
    logic [REG_W-1:0]  w_r1sel, w_r2sel, w_wsel;
    logic              w_r1re, w_r2re, w_nzp_extra, w_no_rf_write;
    logic              w_nzp_we, w_regfile_we, w_is_jsr, w_is_rti, w_is_branch;
    logic              w_full, w_head_valid, w_hazard, w_push, w_issue;

    assign w_head   = r_mem[r_rd_ptr];
    assign w_op     = w_head[INSN_W-1 -: OP_W];
    assign w_op_idx = 32'(w_op);

    assign w_is_jsr    = (w_op_idx == 32'd8);
    assign w_is_rti    = (w_op_idx == 32'd10);
    assign w_is_branch = (w_op_idx <= 32'd4);
    assign w_r1sel     = w_is_rti ? LINK_REG : w_head[2*REG_W-1:REG_W];
    assign w_r2sel     = w_head[REG_W-1:0];
    assign w_wsel      = w_is_jsr ? LINK_REG : w_head[3*REG_W-1:2*REG_W];

    // Opcode-set membership for the head instruction's read/write enables.
    always_comb begin
        w_r1re        = 1'b0;
        w_r2re        = 1'b0;
        w_nzp_extra   = 1'b0;
        w_no_rf_write = 1'b0;
        case (w_op_idx)
            32'd5, 32'd6, 32'd12, 32'd13, 32'd14, 32'd15, 32'd18, 32'd20, 32'd21: begin
                w_r1re = 1'b1;
                w_r2re = 1'b1;
            end
            32'd7, 32'd9, 32'd16, 32'd19, 32'd22, 32'd25: w_r1re = 1'b1;
            default: ;
        endcase
        case (w_op_idx)
            32'd8, 32'd11, 32'd23, 32'd24, 32'd25: w_nzp_extra = 1'b1;
            default: ;
        endcase
        case (w_op_idx)
            32'd16, 32'd19, 32'd24, 32'd25: w_no_rf_write = 1'b1;
            default: ;
        endcase
    end

    assign w_nzp_we     = w_r1re | w_nzp_extra;
    assign w_regfile_we = w_nzp_we & ~w_no_rf_write;

    assign w_full       = (r_count == CNT_W'(DEPTH));
    assign w_head_valid = (r_count != '0);
    // Scoreboard is read from registered state only; a same-cycle writeback does not bypass.
    assign w_hazard     = w_head_valid & ((w_r1re & r_pending[w_r1sel]) |
                                          (w_r2re & r_pending[w_r2sel]) |
                                          (w_regfile_we & r_pending[w_wsel]));
    assign w_push       = i_in_valid & ~w_full;
    assign w_issue      = w_head_valid & ~w_hazard & (~o_out_valid | i_out_ready);

    assign o_in_ready     = ~w_full;
    assign o_stall_hazard = w_hazard;
    assign o_count        = r_count;

    // FIFO pointers and occupancy; flush empties the queue and drops any push/pop.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_issue) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage write at the tail.
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_flush && w_push) r_mem[r_wr_ptr] <= i_in_insn;
    end

    // Output bundle register: load on issue, drop on consume, hold while stalled by execute.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_out_valid              <= 1'b0;
            o_out_insn               <= '0;
            o_out_r1sel              <= '0;
            o_out_r2sel              <= '0;
            o_out_wsel               <= '0;
            o_out_r1re               <= 1'b0;
            o_out_r2re               <= 1'b0;
            o_out_regfile_we         <= 1'b0;
            o_out_nzp_we             <= 1'b0;
            o_out_select_pc_plus_one <= 1'b0;
            o_out_is_branch          <= 1'b0;
            o_out_is_control_insn    <= 1'b0;
        end else if (i_flush) begin
            o_out_valid <= 1'b0;
        end else if (w_issue) begin
            o_out_valid              <= 1'b1;
            o_out_insn               <= w_head;
            o_out_r1sel              <= w_r1sel;
            o_out_r2sel              <= w_r2sel;
            o_out_wsel               <= w_wsel;
            o_out_r1re               <= w_r1re;
            o_out_r2re               <= w_r2re;
            o_out_regfile_we         <= w_regfile_we;
            o_out_nzp_we             <= w_nzp_we;
            o_out_select_pc_plus_one <= w_is_jsr;
            o_out_is_branch          <= w_is_branch;
            o_out_is_control_insn    <= w_is_jsr | w_is_rti;
        end else if (i_out_ready) begin
            o_out_valid <= 1'b0;
        end
    end

    // Pending-write scoreboard; the set is written last so it wins over a same-register clear.
    // Flush leaves it intact because in-flight producers still retire through writeback.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending <= '0;
        end else begin
            if (i_wb_valid) r_pending[i_wb_sel] <= 1'b0;
            if (w_issue && !i_flush && w_regfile_we) r_pending[w_wsel] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lc4_decode_queue.sv
// Bench for lc4_decode_queue: directed scenarios followed by randomized traffic, all checked
// against a queue-based reference model built directly from the opcode tables.
module tb_lc4_decode_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready, wb_valid;
    logic [19:0] in_insn;
    logic [4:0]  wb_sel;
    logic        in_ready, out_valid, r1re, r2re, rf_we, nzp_we, pc1, is_br, is_ctl, stall;
    logic [19:0] out_insn;
    logic [4:0]  r1sel, r2sel, wsel;
    logic [2:0]  count;

    always #5 clk = ~clk;

    lc4_decode_queue dut (
        .i_clk(clk), .i_rst(rst), .i_in_insn(in_insn), .i_in_valid(in_valid),
        .o_in_ready(in_ready), .i_flush(flush), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_out_insn(out_insn), .o_out_r1sel(r1sel),
        .o_out_r2sel(r2sel), .o_out_wsel(wsel), .o_out_r1re(r1re), .o_out_r2re(r2re),
        .o_out_regfile_we(rf_we), .o_out_nzp_we(nzp_we), .o_out_select_pc_plus_one(pc1),
        .o_out_is_branch(is_br), .o_out_is_control_insn(is_ctl), .i_wb_valid(wb_valid),
        .i_wb_sel(wb_sel), .o_stall_hazard(stall), .o_count(count)
    );

    typedef struct packed {
        logic [19:0] insn;
        logic [4:0]  r1, r2, w;
        logic        r1re, r2re, we, nzp, pc1, br, ctl;
    } bundle_t;

    logic [19:0] m_q[$];
    bit          m_ov;
    bundle_t     m_out;
    bit [31:0]   m_pend;
    int          total = 0;
    int          bad = 0;

    function automatic logic [19:0] mk(int unsigned op, int unsigned rd, int unsigned rs,
                                       int unsigned rt);
        return {5'(op), 5'(rd), 5'(rs), 5'(rt)};
    endfunction

    function automatic bundle_t ref_decode(logic [19:0] insn);
        bundle_t b;
        int op;
        op     = int'(insn[19:15]);
        b.insn = insn;
        b.br   = (op <= 4);
        b.r1   = (op == 10) ? 5'd7 : insn[9:5];
        b.r2   = insn[4:0];
        b.w    = (op == 8) ? 5'd7 : insn[14:10];
        b.r1re = op inside {5, 6, 7, 9, 12, 13, 14, 15, 16, 18, 19, 20, 21, 22, 25};
        b.r2re = op inside {5, 6, 12, 13, 14, 15, 18, 20, 21};
        b.nzp  = b.r1re || (op inside {11, 8, 23, 24, 25});
        b.we   = b.nzp && !(op inside {16, 19, 24, 25});
        b.pc1  = (op == 8);
        b.ctl  = (op == 8) || (op == 10);
        return b;
    endfunction

    function automatic bit ref_hazard();
        bundle_t d;
        if (m_q.size() == 0) return 1'b0;
        d = ref_decode(m_q[0]);
        return (d.r1re && m_pend[d.r1]) || (d.r2re && m_pend[d.r2]) || (d.we && m_pend[d.w]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
        check("count", 32'(count), 32'(m_q.size()));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("stall_hazard", 32'(stall), 32'(ref_hazard()));
        if (m_ov) begin
            check("out_insn", 32'(out_insn), 32'(m_out.insn));
            check("out_sels", 32'({r1sel, r2sel, wsel}), 32'({m_out.r1, m_out.r2, m_out.w}));
            check("out_flags", 32'({r1re, r2re, rf_we, nzp_we, pc1, is_br, is_ctl}),
                  32'({m_out.r1re, m_out.r2re, m_out.we, m_out.nzp, m_out.pc1, m_out.br,
                       m_out.ctl}));
        end
    endtask

    task automatic model_update();
        bundle_t d;
        bit      iss;
        int      sz;
        if (rst) begin
            m_q.delete();
            m_ov   = 1'b0;
            m_out  = '0;
            m_pend = '0;
        end else begin
            sz  = m_q.size();
            iss = (sz > 0) && !ref_hazard() && (!m_ov || out_ready);
            d   = (sz > 0) ? ref_decode(m_q[0]) : '0;
            if (wb_valid) m_pend[wb_sel] = 1'b0;
            if (iss && !flush && d.we) m_pend[d.w] = 1'b1;
            if (flush) begin
                m_q.delete();
                m_ov = 1'b0;
            end else begin
                if (iss) begin
                    void'(m_q.pop_front());
                    m_ov  = 1'b1;
                    m_out = d;
                end else if (out_ready) begin
                    m_ov = 1'b0;
                end
                if (in_valid && sz < DEPTH) m_q.push_back(in_insn);
            end
        end
    endtask

    // Check the current state, then advance one clock and update the model.
    task automatic step();
        #2;
        check_all();
        @(posedge clk);
        #1;
        model_update();
    endtask

    initial begin
        logic [19:0] lst[6];
        int          idx, k;
        bit          acc;

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        wb_valid = 1'b0; wb_sel = '0; in_insn = '0;
        repeat (2) @(posedge clk);
        #1;
        model_update();
        check("reset_ctl", 32'({out_valid, in_ready, stall, count}), 32'(6'b010000));
        check("reset_fields_a", 32'(out_insn), 32'd0);
        check("reset_fields_b", 32'({r1sel, r2sel, wsel, r1re, r2re, rf_we, nzp_we, pc1,
                                     is_br, is_ctl}), 32'd0);
        rst = 1'b0;

        // ADD rd=3 rs=1 rt=2: two-edge latency, sets pending[3]
        out_ready = 1'b1; in_valid = 1'b1; in_insn = mk(5, 3, 1, 2);
        step();
        in_valid = 1'b0;
        check("t1_not_yet", 32'(out_valid), 32'd0);
        step();
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_enables", 32'({r1re, r2re, rf_we, nzp_we}), 32'(4'b1111));
        check("t1_wsel", 32'(wsel), 32'd3);

        // SUB reading r3 stalls until writeback of r3
        in_valid = 1'b1; in_insn = mk(6, 5, 3, 2);
        step();
        in_valid = 1'b0;
        check("t2_stall", 32'({stall, out_valid}), 32'(2'b10));
        step();
        wb_valid = 1'b1; wb_sel = 5'd3;
        check("t2_stall_at_wb", 32'(stall), 32'd1);
        step();
        wb_valid = 1'b0;
        check("t2_cleared", 32'({stall, out_valid}), 32'(2'b00));
        step();
        check("t2_issued", 32'({out_valid, r1sel}), 32'({1'b1, 5'd3}));
        wb_valid = 1'b1; wb_sel = 5'd5;
        step();
        wb_valid = 1'b0;

        // Fill with out_ready low: four queued plus one held, sixth held by fetch
        for (int i = 0; i < 6; i++) lst[i] = mk(1, i, i + 1, i + 2);
        out_ready = 1'b0; idx = 0;
        for (int c = 0; c < 7; c++) begin
            in_valid = (idx < 6);
            in_insn  = lst[idx < 6 ? idx : 5];
            acc      = in_valid && in_ready;
            step();
            if (acc) idx++;
        end
        check("t3_accepted", 32'(idx), 32'd5);
        check("t3_full", 32'({in_ready, count, out_valid}), 32'({1'b0, 3'd4, 1'b1}));
        check("t3_head_out", 32'(out_insn), 32'(lst[0]));
        out_ready = 1'b1; k = 0;
        for (int c = 0; c < 16; c++) begin
            in_valid = (idx < 6);
            in_insn  = lst[idx < 6 ? idx : 5];
            acc      = in_valid && in_ready;
            if (out_valid && k < 6) begin
                check("t3_order", 32'(out_insn), 32'(lst[k]));
                k++;
            end
            step();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("t3_drained", 32'(k), 32'd6);

        // JSR then RTI
        in_valid = 1'b1; in_insn = mk(8, 2, 3, 4);
        step();
        in_valid = 1'b0;
        step();
        check("t4_jsr", 32'({wsel, pc1, is_ctl, rf_we}), 32'({5'd7, 3'b111}));
        in_valid = 1'b1; in_insn = mk(10, 1, 2, 3);
        step();
        in_valid = 1'b0;
        step();
        check("t4_rti", 32'({r1sel, r1re, rf_we, is_ctl}), 32'({5'd7, 3'b001}));
        wb_valid = 1'b1; wb_sel = 5'd7;
        step();
        wb_valid = 1'b0;

        // CHKL rd=4 does not mark r4; a reader of r4 then issues freely; BRz has no enables
        in_valid = 1'b1; in_insn = mk(16, 4, 1, 2);
        step();
        in_valid = 1'b0;
        step();
        check("t5_chkl", 32'({nzp_we, rf_we, r1re}), 32'(3'b101));
        in_valid = 1'b1; in_insn = mk(5, 6, 4, 4);
        step();
        in_valid = 1'b0;
        check("t5_no_stall", 32'(stall), 32'd0);
        in_valid = 1'b1; in_insn = mk(1, 2, 3, 4);
        step();
        in_valid = 1'b0;
        step();
        check("t5_brz", 32'({is_br, r1re, r2re, rf_we, nzp_we, is_ctl}), 32'(6'b100000));
        wb_valid = 1'b1; wb_sel = 5'd6;
        step();
        wb_valid = 1'b0;

        // Flush with three queued while pending[4] is outstanding
        in_valid = 1'b1; in_insn = mk(5, 4, 1, 2);
        step();
        for (int i = 0; i < 3; i++) begin
            in_insn = mk(1, i, i, i);
            step();
            out_ready = 1'b0;
        end
        in_valid = 1'b0;
        check("t6_queued", 32'(count), 32'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t6_flushed", 32'({count, out_valid, in_ready}), 32'({3'd0, 2'b01}));
        in_valid = 1'b1; in_insn = mk(5, 7, 4, 1);
        step();
        in_valid = 1'b0;
        check("t6_pending_kept", 32'(stall), 32'd1);
        wb_valid = 1'b1; wb_sel = 5'd4;
        step();
        wb_valid = 1'b0;
        step();
        check("t6_issue_after_wb", 32'({out_valid, r1sel}), 32'({1'b1, 5'd4}));
        out_ready = 1'b1;
        wb_valid = 1'b1; wb_sel = 5'd7;
        step();
        wb_valid = 1'b0;

        // Randomized traffic with occasional flush and mid-operation reset
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_insn   = mk($urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 7),
                           $urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
            wb_valid  = 1'($urandom_range(0, 1));
            wb_sel    = 5'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 31) == 0);
            rst       = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; wb_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
